// File: rtl/pavana_xbar_pkg.sv
// pavana_xbar_pkg: shared crossbar bus definitions.
//   CMD_RD / CMD_WR : cmd encodings on the req bus
//   DATA_W          : bus data width
//   SNUM_MSB/LSB    : slave-select field inside the byte address
//   bus_req_t       : one request beat {addr, cmd, wdata}
package pavana_xbar_pkg;
  localparam logic CMD_RD   = 1'b0;
  localparam logic CMD_WR   = 1'b1;
  localparam int   DATA_W   = 32;
  localparam int   SNUM_MSB = 31;
  localparam int   SNUM_LSB = 30;

  typedef struct packed {
    logic [31:0]       addr;
    logic              cmd;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;
endpackage

// File: rtl/pavana_rd_pipe.sv
// pavana_rd_pipe: DEPTH-stage valid/data shift register (read return pipe).
// Ports:
//   clk_i, rst_i (async, active-low)
//   in_vld / in_data   : stage-0 load, sampled every rising edge
//   out_vld / out_data : last stage, DEPTH edges after load
module pavana_rd_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [DEPTH-1:0][W-1:0] data_q, data_d;

  always_comb begin
    vld_d     = '0;
    data_d    = '0;
    vld_d[0]  = in_vld;
    data_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];
endmodule

// File: rtl/pavana_slave_sram.sv
// pavana_slave_sram: SRAM-backed crossbar slave endpoint.
//   Writes are posted (complete on accept, no resp). Reads return in order
//   RD_LATENCY cycles after accept as a one-cycle resp_o pulse. ack_o is
//   withheld from reads while MAX_OUT reads are in flight.
// Ports:
//   clk_i, rst_i (async, active-low)
//   req_i, addr_i[31:0], cmd_i, wdata_i[31:0] : request, held until ack_o
//   ack_o                                      : combinational accept
//   resp_o, rdata_o[31:0]                      : read response (rdata 0 when idle)
// Optional build macro: PAVANA_SLAVE_STALL_EN adds an LFSR that randomly
//   denies ~25% of acks for stress testing.
module pavana_slave_sram
  import pavana_xbar_pkg::*;
#(
  parameter int          ADDR_W     = 10,
  parameter int          RD_LATENCY = 2,
  parameter int          MAX_OUT    = 4,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [31:0]       addr_i,
  input  logic              cmd_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              resp_o
);
  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  bus_req_t          req;
  logic [ADDR_W-1:0] idx;
  logic              stall, rd_acc, wr_acc;
  logic [3:0]        out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] pipe_data;
  logic              unused_addr_bits;

  assign req = '{addr: addr_i, cmd: cmd_i, wdata: wdata_i};
  // Slave-select and byte-offset bits do not take part in decode, so the
  // word index aliases modulo the memory depth.
  assign idx = req.addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{req.addr[SNUM_MSB:ADDR_W+2], req.addr[1:0]};

`ifdef PAVANA_SLAVE_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;
  // Fibonacci LFSR, taps 16,14,13,11.
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) lfsr_q <= STALL_SEED;
    else        lfsr_q <= lfsr_d;
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  logic unused_seed;
  assign unused_seed = ^STALL_SEED;
  assign stall = 1'b0;
`endif

  // The cap only throttles reads; posted writes never wait.
  assign ack_o  = req_i & ~stall & ((req.cmd == CMD_WR) | (out_cnt_q < MAX_OUT_C));
  assign wr_acc = ack_o & (req.cmd == CMD_WR);
  assign rd_acc = ack_o & (req.cmd == CMD_RD);

  // Memory is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[idx] <= req.wdata;
  end

  // Read data is sampled at the accept edge into pipe stage 0.
  pavana_rd_pipe #(.DEPTH(RD_LATENCY), .W(DATA_W)) u_rd_pipe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_vld   (rd_acc),
    .in_data  (mem[idx]),
    .out_vld  (resp_o),
    .out_data (pipe_data)
  );

  assign rdata_o = resp_o ? pipe_data : '0;

  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({rd_acc, resp_o})
      2'b10:   out_cnt_d = out_cnt_q + 4'd1;
      2'b01:   out_cnt_d = out_cnt_q - 4'd1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) out_cnt_q <= '0;
    else        out_cnt_q <= out_cnt_d;
  end
endmodule
